// File: rtl/stream_parity_acc.sv
// Streaming frame parity accumulator.
// Every accepted word is XOR-reduced into a running frame parity; the last
// beat of a frame loads a one-entry result buffer (parity, saturating beat
// count, overflow flag) that drains under valid/ready backpressure.
module stream_parity_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    // Frame-in-progress state, never visible until the last beat.
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    // Result buffer.
    logic             r_out_valid;
    logic             r_out_parity;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;

    logic             w_accept;
    logic             w_pop;
    logic             w_par;
    logic             w_cnt_max;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;

    // A full buffer that is being drained this cycle can still take a beat.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_pop      = r_out_valid && out_ready;

    // Running parity including the current word, and the saturating count.
    assign w_par      = r_acc ^ (^in_data);
    assign w_cnt_max  = &r_cnt;
    assign w_cnt_next = w_cnt_max ? r_cnt : r_cnt + CNT_W'(1);
    assign w_ovf_next = r_ovf || w_cnt_max;

    // Accumulate non-final beats; clear frame state when the frame closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 1'b0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc <= 1'b0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_par;
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_next;
            end
        end
    end

    // Load the result on the last beat; fields hold after a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_parity <= 1'b0;
            r_out_count  <= '0;
            r_out_ovf    <= 1'b0;
        end else if (w_accept && in_last) begin
            r_out_valid  <= 1'b1;
            r_out_parity <= w_par ^ odd_mode;
            r_out_count  <= w_cnt_next;
            r_out_ovf    <= w_ovf_next;
        end else if (w_pop) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_parity = r_out_parity;
    assign out_count  = r_out_count;
    assign out_ovf    = r_out_ovf;

endmodule

// File: tb/tb_stream_parity_acc.sv
// Directed bench for stream_parity_acc. Two instances share one stimulus
// stream: u0 with the default 8-bit counter, u1 with a 2-bit counter so
// saturation is reachable in a handful of beats.
module tb_stream_parity_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       odd_mode;
    logic       out_ready;

    logic       rdy0, vld0, par0, ovf0;
    logic [7:0] cnt0;
    logic       rdy1, vld1, par1, ovf1;
    logic [1:0] cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_parity_acc #(.WIDTH(8), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(vld0), .out_ready(out_ready), .out_parity(par0),
        .out_count(cnt0), .out_ovf(ovf0)
    );

    stream_parity_acc #(.WIDTH(8), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(vld1), .out_ready(out_ready), .out_parity(par1),
        .out_count(cnt1), .out_ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic odd);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        odd_mode = odd;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] d;
        logic       o;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        odd_mode = 1'b0; out_ready = 1'b0;
        step();
        chk("rst_in_ready", rdy0, 1);
        chk("rst_valid", vld0, 0);
        chk("rst_parity", par0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_ovf", ovf0, 0);
        step();
        rst = 1'b0;

        // Single-beat frames, even then odd result.
        out_ready = 1'b1;
        beat(8'hA5, 1'b1, 1'b0);
        chk("single_valid", vld0, 1);
        chk("single_parity", par0, 0);
        chk("single_count", cnt0, 1);
        chk("single_ovf", ovf0, 0);
        beat(8'hA5, 1'b1, 1'b1);
        chk("single_odd_valid", vld0, 1);
        chk("single_odd_parity", par0, 1);
        idle();
        chk("pop_valid", vld0, 0);
        chk("pop_hold_parity", par0, 1);
        chk("pop_hold_count", cnt0, 1);

        // Multi-beat frames.
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h03, 1'b0, 1'b0);
        chk("midframe_hidden", vld0, 0);
        beat(8'h07, 1'b1, 1'b0);
        chk("three_parity", par0, 0);
        chk("three_count", cnt0, 3);
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h03, 1'b1, 1'b0);
        chk("two_parity", par0, 1);
        chk("two_count", cnt0, 2);
        idle();

        // Backpressure: A held, B stalls, then both move in one cycle.
        out_ready = 1'b0;
        beat(8'hFF, 1'b1, 1'b0);
        chk("bp_a_valid", vld0, 1);
        chk("bp_a_parity", par0, 0);
        chk("bp_in_ready_low", rdy0, 0);
        beat(8'h80, 1'b1, 1'b0);
        chk("bp_stall_ready", rdy0, 0);
        chk("bp_stall_valid", vld0, 1);
        chk("bp_stall_parity", par0, 0);
        chk("bp_stall_count", cnt0, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_drain_ready", rdy0, 1);
        step();
        chk("bp_b_valid", vld0, 1);
        chk("bp_b_parity", par0, 1);
        chk("bp_b_count", cnt0, 1);
        idle();
        chk("bp_b_popped", vld0, 0);

        // Saturation on the 2-bit counter instance.
        for (int i = 0; i < 4; i++) beat(8'h01, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 1'b0);
        chk("sat_count", cnt1, 3);
        chk("sat_ovf", ovf1, 1);
        chk("sat_parity", par1, 1);
        chk("wide_count", cnt0, 5);
        chk("wide_ovf", ovf0, 0);
        beat(8'h01, 1'b1, 1'b0);
        chk("sat_after_ovf", ovf1, 0);
        chk("sat_after_count", cnt1, 1);
        idle();

        // Reset mid-frame drops the partial frame.
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h01, 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("rst_mid_in_ready", rdy0, 1);
        rst = 1'b0;
        beat(8'h01, 1'b1, 1'b0);
        chk("rst_mid_parity", par0, 1);
        chk("rst_mid_count", cnt0, 1);

        // Reset with a pending result.
        out_ready = 1'b0; in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_pending_valid", vld0, 0);
        rst = 1'b0;

        // Throughput: back-to-back single-beat frames, one result per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            o = 1'($urandom);
            in_valid = 1'b1; in_data = d; in_last = 1'b1; odd_mode = o;
            chk("tp_in_ready", rdy0, 1);
            step();
            chk("tp_valid", vld0, 1);
            chk("tp_parity", par0, 32'(($countones(d) % 2) ^ o));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
